// File: rtl/mem_read_router.sv
// mem_read_router: return path of the shared sample-memory read port.
//
// Each read issued to the sample RAM is tagged with its owner (fsm_mux_i at issue time). The tag
// travels down a RD_LATENCY-deep pipeline so it lines up with the returning mem_rdata_i. Data owned
// by the FIR core is delivered as a one-cycle registered pulse; data owned by the AXI slave is
// queued in a small FIFO drained through a valid/ready handshake.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset, synchronous release
//   fsm_mux_i     owner of a read issued this cycle: 1 = AXI, 0 = FIR
//   rd_en_i       a read is issued to the RAM this cycle
//   mem_rdata_i   RAM read data, valid RD_LATENCY cycles after rd_en_i
//   fir_data_o    last word routed to the FIR core (held between pulses)
//   fir_valid_o   one-cycle pulse: fir_data_o updated
//   axi_rdata_o   AXI FIFO head word
//   axi_rvalid_o  AXI FIFO non-empty
//   axi_rready_i  AXI consumer accepts the head word
//   busy_o        reads in flight or AXI FIFO non-empty
//   overflow_o    sticky: an AXI response was dropped because the FIFO was full
module mem_read_router #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned RD_LATENCY = 2,  // 1..4
  parameter int unsigned AXI_DEPTH  = 4   // power of two, 2..16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fsm_mux_i,
  input  logic                  rd_en_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [DATA_WIDTH-1:0] fir_data_o,
  output logic                  fir_valid_o,
  output logic [DATA_WIDTH-1:0] axi_rdata_o,
  output logic                  axi_rvalid_o,
  input  logic                  axi_rready_i,
  output logic                  busy_o,
  output logic                  overflow_o
);

  localparam int unsigned PtrW = $clog2(AXI_DEPTH);
  localparam int unsigned CntW = $clog2(AXI_DEPTH + 1);

  localparam logic [CntW-1:0] CntFull = CntW'(AXI_DEPTH);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);

  // ---------------------------------------------------------------------------------------------
  // Tag pipeline: one {valid, owner} pair per cycle of RAM latency.
  // ---------------------------------------------------------------------------------------------
  logic [RD_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [RD_LATENCY-1:0] tag_own_q, tag_own_d;

  always_comb begin
    tag_vld_d    = '0;
    tag_own_d    = '0;
    tag_vld_d[0] = rd_en_i;
    tag_own_d[0] = fsm_mux_i;
    for (int i = 1; i < int'(RD_LATENCY); i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_own_d[i] = tag_own_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q <= '0;
      tag_own_q <= '0;
    end else begin
      tag_vld_q <= tag_vld_d;
      tag_own_q <= tag_own_d;
    end
  end

  // The last stage describes the word present on mem_rdata_i this cycle.
  logic ret_vld, ret_own;
  logic fir_hit, axi_hit;

  assign ret_vld = tag_vld_q[RD_LATENCY-1];
  assign ret_own = tag_own_q[RD_LATENCY-1];
  assign fir_hit = ret_vld & ~ret_own;
  assign axi_hit = ret_vld &  ret_own;

  // ---------------------------------------------------------------------------------------------
  // FIR path: registered single-cycle pulse, no backpressure.
  // ---------------------------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] fir_data_q, fir_data_d;
  logic                  fir_valid_q, fir_valid_d;

  always_comb begin
    fir_valid_d = fir_hit;
    fir_data_d  = fir_data_q;
    if (fir_hit) begin
      fir_data_d = mem_rdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fir_data_q  <= '0;
      fir_valid_q <= 1'b0;
    end else begin
      fir_data_q  <= fir_data_d;
      fir_valid_q <= fir_valid_d;
    end
  end

  assign fir_data_o  = fir_data_q;
  assign fir_valid_o = fir_valid_q;

  // ---------------------------------------------------------------------------------------------
  // AXI path: response FIFO.
  // ---------------------------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] fifo_q [AXI_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  overflow_q, overflow_d;

  logic not_empty, full;
  logic pop, push, drop;

  assign not_empty = (count_q != '0);
  assign full      = (count_q == CntFull);
  assign pop       = not_empty & axi_rready_i;
  // A simultaneous pop frees the slot, so a push into a full FIFO is still accepted.
  assign push      = axi_hit & (~full | pop);
  assign drop      = axi_hit & full & ~pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;

    // Pointers wrap naturally because AXI_DEPTH is a power of two.
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is cleared on reset so axi_rdata_o reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(AXI_DEPTH); i++) begin
        fifo_q[i] <= '0;
      end
    end else if (push) begin
      fifo_q[wr_ptr_q] <= mem_rdata_i;
    end
  end

  assign axi_rdata_o  = fifo_q[rd_ptr_q];
  assign axi_rvalid_o = not_empty;
  assign overflow_o   = overflow_q;

  // ---------------------------------------------------------------------------------------------
  // Activity indication.
  // ---------------------------------------------------------------------------------------------
  assign busy_o = (|tag_vld_q) | not_empty;

endmodule

// File: tb/tb_mem_read_router.sv
// Directed bench for mem_read_router with a queue-based reference model and literal spot checks.
module tb_mem_read_router;

  localparam int unsigned DW = 16;
  localparam int unsigned L  = 2;
  localparam int unsigned D  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fsm_mux;
  logic          rd_en;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] fir_data;
  logic          fir_valid;
  logic [DW-1:0] axi_rdata;
  logic          axi_rvalid;
  logic          axi_rready;
  logic          busy;
  logic          overflow;

  mem_read_router #(
    .DATA_WIDTH(DW),
    .RD_LATENCY(L),
    .AXI_DEPTH (D)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fsm_mux_i   (fsm_mux),
    .rd_en_i     (rd_en),
    .mem_rdata_i (mem_rdata),
    .fir_data_o  (fir_data),
    .fir_valid_o (fir_valid),
    .axi_rdata_o (axi_rdata),
    .axi_rvalid_o(axi_rvalid),
    .axi_rready_i(axi_rready),
    .busy_o      (busy),
    .overflow_o  (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------------------------
  // Reference model: reads in flight are a list of due cycles; the AXI FIFO is a queue.
  // ---------------------------------------------------------------------------------------------
  typedef struct {
    int   due;
    logic own;
  } rd_t;

  int            cyc = 0;
  rd_t           pend[$];
  logic [DW-1:0] m_fifo[$];
  logic          m_fir_v;
  logic [DW-1:0] m_fir_d;
  logic          m_ovf;
  logic [DW-1:0] ram_at[int];

  task automatic model_clear();
    pend.delete();
    m_fifo.delete();
    m_fir_v = 1'b0;
    m_fir_d = '0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_step();
    logic got_axi;
    logic popped;
    logic was_full;
    rd_t  r;
    got_axi = 1'b0;
    m_fir_v = 1'b0;
    if (pend.size() != 0 && pend[0].due == cyc) begin
      r = pend.pop_front();
      if (r.own) got_axi = 1'b1;
      else begin
        m_fir_v = 1'b1;
        m_fir_d = mem_rdata;
      end
    end
    was_full = (m_fifo.size() == D);
    popped   = (m_fifo.size() != 0) && axi_rready;
    if (popped) void'(m_fifo.pop_front());
    if (got_axi) begin
      if (!was_full || popped) m_fifo.push_back(mem_rdata);
      else m_ovf = 1'b1;
    end
    if (rd_en) pend.push_back('{due: cyc + L, own: fsm_mux});
  endtask

  always @(posedge clk) begin
    if (rst_n) model_step();
    else model_clear();
    cyc++;
  end

  always @(negedge rst_n) model_clear();

  // Per-cycle comparison against the model, plus capture of delivered words.
  logic [DW-1:0] fir_seen[$];
  logic [DW-1:0] axi_seen[$];

  always @(negedge clk) begin
    if (rst_n) begin
      chk("fir_valid", 32'(fir_valid), 32'(m_fir_v));
      chk("fir_data", 32'(fir_data), 32'(m_fir_d));
      chk("axi_rvalid", 32'(axi_rvalid), 32'(m_fifo.size() != 0));
      if (m_fifo.size() != 0) chk("axi_rdata", 32'(axi_rdata), 32'(m_fifo[0]));
      chk("busy", 32'(busy), 32'((pend.size() != 0) || (m_fifo.size() != 0)));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (fir_valid) fir_seen.push_back(fir_data);
      if (axi_rvalid && axi_rready) axi_seen.push_back(axi_rdata);
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Stimulus helpers. Inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
    rd_en     = 1'b0;
    mem_rdata = ram_at.exists(cyc) ? ram_at[cyc] : 16'hDEAD;
  endtask

  task automatic issue(input logic owner, input logic [DW-1:0] data);
    rd_en          = 1'b1;
    fsm_mux        = owner;
    ram_at[cyc+L]  = data;
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " fir_data"}, 32'(fir_data), 32'h0);
    chk({tag, " fir_valid"}, 32'(fir_valid), 32'h0);
    chk({tag, " axi_rdata"}, 32'(axi_rdata), 32'h0);
    chk({tag, " axi_rvalid"}, 32'(axi_rvalid), 32'h0);
    chk({tag, " busy"}, 32'(busy), 32'h0);
    chk({tag, " overflow"}, 32'(overflow), 32'h0);
  endtask

  task automatic check_seen(input string name, input logic [DW-1:0] got[$],
                            input logic [DW-1:0] exp[$]);
    chk({name, " count"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got.size()) chk(name, 32'(got[i]), 32'(exp[i]));
    end
  endtask

  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;
    fir_seen.delete();
    axi_seen.delete();
  endtask

  logic [DW-1:0] exp_q[$];

  initial begin
    rst_n      = 1'b0;
    fsm_mux    = 1'b0;
    rd_en      = 1'b0;
    mem_rdata  = '0;
    axi_rready = 1'b0;
    model_clear();
    repeat (3) tick();
    chk_all_zero("por");
    rst_n = 1'b1;

    // 1: single FIR read issued in cycle 10.
    while (cyc < 10) tick();
    issue(1'b0, 16'h1234);                     // now cycle 11
    tick();                                    // cycle 12: data on the bus
    chk("t1 early fir_valid", 32'(fir_valid), 32'h0);
    tick();                                    // cycle 13
    chk("t1 cycle", 32'(cyc), 32'd13);
    chk("t1 fir_valid", 32'(fir_valid), 32'h1);
    chk("t1 fir_data", 32'(fir_data), 32'h1234);
    chk("t1 axi_rvalid", 32'(axi_rvalid), 32'h0);
    tick();
    chk("t1 fir_valid drop", 32'(fir_valid), 32'h0);
    chk("t1 fir_data hold", 32'(fir_data), 32'h1234);

    // 2: alternating owners, AXI always ready.
    fir_seen.delete();
    axi_seen.delete();
    axi_rready = 1'b1;
    issue(1'b0, 16'h00A0);
    issue(1'b1, 16'h00A1);
    issue(1'b0, 16'h00A2);
    issue(1'b1, 16'h00A3);
    repeat (6) tick();
    exp_q = {};
    exp_q.push_back(16'h00A0);
    exp_q.push_back(16'h00A2);
    check_seen("t2 fir", fir_seen, exp_q);
    exp_q = {};
    exp_q.push_back(16'h00A1);
    exp_q.push_back(16'h00A3);
    check_seen("t2 axi", axi_seen, exp_q);
    chk("t2 busy idle", 32'(busy), 32'h0);
    axi_rready = 1'b0;

    // 3: owner select changes while an AXI read is in flight.
    fir_seen.delete();
    axi_seen.delete();
    issue(1'b1, 16'h0BEE);
    fsm_mux = 1'b0;
    repeat (3) tick();
    chk("t3 axi_rvalid", 32'(axi_rvalid), 32'h1);
    chk("t3 axi_rdata", 32'(axi_rdata), 32'h0BEE);
    chk("t3 fir count", 32'(fir_seen.size()), 32'h0);
    axi_rready = 1'b1;
    tick();
    axi_rready = 1'b0;
    tick();
    chk("t3 drained", 32'(axi_rvalid), 32'h0);

    // 4: six AXI reads into a four-entry FIFO with no consumer.
    axi_seen.delete();
    for (int i = 0; i < 6; i++) issue(1'b1, DW'(16'h0010 + i));
    repeat (L + 1) tick();
    chk("t4 overflow", 32'(overflow), 32'h1);
    chk("t4 head", 32'(axi_rdata), 32'h0010);
    axi_rready = 1'b1;
    repeat (5) tick();
    axi_rready = 1'b0;
    exp_q = {};
    for (int i = 0; i < 4; i++) exp_q.push_back(DW'(16'h0010 + i));
    check_seen("t4 axi", axi_seen, exp_q);
    chk("t4 overflow sticky", 32'(overflow), 32'h1);

    // 5: push into a full FIFO coincides with a pop.
    do_reset();
    for (int i = 0; i < 4; i++) issue(1'b1, DW'(16'h0020 + i));
    repeat (L) tick();
    issue(1'b1, 16'h0024);                     // data returns L cycles after issue
    repeat (L - 1) tick();
    axi_rready = 1'b1;                         // pop in the cycle of the push
    tick();
    axi_rready = 1'b0;
    tick();
    chk("t5 overflow", 32'(overflow), 32'h0);
    chk("t5 head", 32'(axi_rdata), 32'h0021);
    axi_rready = 1'b1;
    repeat (5) tick();
    axi_rready = 1'b0;
    exp_q = {};
    for (int i = 0; i < 5; i++) exp_q.push_back(DW'(16'h0020 + i));
    check_seen("t5 axi", axi_seen, exp_q);
    chk("t5 overflow end", 32'(overflow), 32'h0);

    // 6: reset with three queued AXI words and two reads in flight.
    issue(1'b1, 16'h0030);
    issue(1'b1, 16'h0031);
    issue(1'b1, 16'h0032);
    repeat (L) tick();
    issue(1'b0, 16'h0040);
    issue(1'b1, 16'h0041);
    chk("t6 pre busy", 32'(busy), 32'h1);
    chk("t6 pre rvalid", 32'(axi_rvalid), 32'h1);
    do_reset();
    axi_rready = 1'b1;
    repeat (6) tick();
    axi_rready = 1'b0;
    chk("t6 fir after", 32'(fir_seen.size()), 32'h0);
    chk("t6 axi after", 32'(axi_seen.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
